// File: rtl/arcade_audio_pkg.sv
// Shared types and sizing helpers for the arcade audio mixer.
// Imported by the mixer top and the sigma-delta DAC.
package arcade_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    NORM
  } mix_state_t;

  function automatic int clog2i(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Accumulator width that can never wrap for NCH full-scale products.
  function automatic int acc_width(input int dw,
                                   input int gw,
                                   input int nch);
    return dw + gw + clog2i(nch) + 1;
  endfunction

endpackage

// File: rtl/audio_sd_dac.sv
// First-order sigma-delta modulator: one integrator,
// carry out is the registered 1-bit stream.
module audio_sd_dac
  import arcade_audio_pkg::*;
#(
  parameter int OW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [OW-1:0] pcm_i,
  output logic          dac_o
);

  logic [OW-1:0] integ_q;
  logic          dac_q;
  logic [OW:0]   sum_d;

  assign sum_d = {1'b0, integ_q} + {1'b0, pcm_i};
  assign dac_o = dac_q;

  // Integrate the PCM value; overflow carry becomes the output bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      integ_q <= '0;
      dac_q   <= 1'b0;
    end else begin
      integ_q <= sum_d[OW-1:0];
      dac_q   <= sum_d[OW];
    end
  end

endmodule

// File: rtl/arcade_audio_mixer.sv
// Time-multiplexed N-channel PCM mixer with gain, routing,
// saturation and sigma-delta stereo outputs.
module arcade_audio_mixer
  import arcade_audio_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 7,
  parameter int GW    = 4,
  parameter int SHIFT = $clog2(NCH)
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               sample_stb,
  input  logic [NCH*DW-1:0]  ch_data,
  input  logic [NCH*GW-1:0]  ch_gain,
  input  logic [NCH*2-1:0]   ch_pan,
  input  logic               mono,
  input  logic               mute,
  output logic [DW+GW-1:0]   pcm_l,
  output logic [DW+GW-1:0]   pcm_r,
  output logic               pcm_stb,
  output logic               overrun,
  output logic               dac_l,
  output logic               dac_r
);

  localparam int OW = DW + GW;
  localparam int AW = acc_width(DW, GW, NCH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  mix_state_t state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     acc_l_q, acc_l_d;
  logic [AW-1:0]     acc_r_q, acc_r_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [NCH*GW-1:0] gain_q, gain_d;
  logic [NCH*2-1:0]  pan_q, pan_d;
  logic              mono_q, mono_d;
  logic              mute_q, mute_d;
  logic [OW-1:0]     pcm_l_q, pcm_l_d;
  logic [OW-1:0]     pcm_r_q, pcm_r_d;
  logic              stb_q, stb_d;
  logic              ovr_q, ovr_d;

  logic [DW-1:0] cur_data;
  logic [GW-1:0] cur_gain;
  logic [OW-1:0] prod;
  logic          route_l;
  logic          route_r;
  logic [AW-1:0] sum_l;
  logic [AW-1:0] sum_r;

  // Clip a shifted accumulator to the PCM range.
  function automatic logic [OW-1:0] sat(
    input logic [AW-1:0] a
  );
    logic [AW-1:0] s;
    s = a >> SHIFT;
    if (s > AW'({OW{1'b1}})) return {OW{1'b1}};
    return s[OW-1:0];
  endfunction

  // Shared multiplier fed by the snapshot of the current channel.
  always_comb begin
    cur_data = data_q[int'(idx_q)*DW +: DW];
    cur_gain = gain_q[int'(idx_q)*GW +: GW];
    route_l  = mono_q | pan_q[int'(idx_q)*2];
    route_r  = mono_q | pan_q[int'(idx_q)*2+1];
    prod     = OW'(cur_data) * OW'(cur_gain);
    sum_l    = acc_l_q + (route_l ? AW'(prod) : '0);
    sum_r    = acc_r_q + (route_r ? AW'(prod) : '0);
  end

  // Mix sequencer: snapshot, accumulate, normalise.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    data_d  = data_q;
    gain_d  = gain_q;
    pan_d   = pan_q;
    mono_d  = mono_q;
    mute_d  = mute_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    stb_d   = 1'b0;
    ovr_d   = sample_stb && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (sample_stb) begin
          data_d  = ch_data;
          gain_d  = ch_gain;
          pan_d   = ch_pan;
          mono_d  = mono;
          mute_d  = mute;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        if (idx_q == LAST) begin
          pcm_l_d = mute_q ? '0 : sat(sum_l);
          pcm_r_d = mute_q ? '0 : sat(sum_r);
          stb_d   = 1'b1;
          state_d = NORM;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      NORM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      data_q  <= '0;
      gain_q  <= '0;
      pan_q   <= '0;
      mono_q  <= 1'b0;
      mute_q  <= 1'b0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      stb_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      data_q  <= data_d;
      gain_q  <= gain_d;
      pan_q   <= pan_d;
      mono_q  <= mono_d;
      mute_q  <= mute_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      stb_q   <= stb_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pcm_l   = pcm_l_q;
  assign pcm_r   = pcm_r_q;
  assign pcm_stb = stb_q;
  assign overrun = ovr_q;

  audio_sd_dac #(.OW(OW)) u_sd_l (
    .clk_i (clk_sys),
    .rst_i (reset),
    .pcm_i (pcm_l_q),
    .dac_o (dac_l)
  );

  audio_sd_dac #(.OW(OW)) u_sd_r (
    .clk_i (clk_sys),
    .rst_i (reset),
    .pcm_i (pcm_r_q),
    .dac_o (dac_r)
  );

endmodule

// File: tb/tb_arcade_audio_mixer.sv
// Directed bench for arcade_audio_mixer: SHIFT=1 and SHIFT=0
// instances share stimulus; expectations are hand-computed.
module tb_arcade_audio_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_stb;
  logic [13:0] ch_data;
  logic [7:0]  ch_gain;
  logic [3:0]  ch_pan;
  logic        mono;
  logic        mute;

  logic [10:0] pcm_l0, pcm_r0, pcm_l1, pcm_r1;
  logic        pstb0, pstb1, ovr0, ovr1;
  logic        dl0, dr0, dl1, dr1;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  arcade_audio_mixer #(.NCH(2), .DW(7), .GW(4)) u0 (
    .clk_sys(clk), .reset(reset), .sample_stb(sample_stb),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_pan(ch_pan),
    .mono(mono), .mute(mute),
    .pcm_l(pcm_l0), .pcm_r(pcm_r0), .pcm_stb(pstb0),
    .overrun(ovr0), .dac_l(dl0), .dac_r(dr0)
  );

  arcade_audio_mixer #(.NCH(2), .DW(7), .GW(4), .SHIFT(0)) u1 (
    .clk_sys(clk), .reset(reset), .sample_stb(sample_stb),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_pan(ch_pan),
    .mono(mono), .mute(mute),
    .pcm_l(pcm_l1), .pcm_r(pcm_r1), .pcm_stb(pstb1),
    .overrun(ovr1), .dac_l(dl1), .dac_r(dr1)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int d0, input int g0, input int p0,
                        input int d1, input int g1, input int p1);
    ch_data = {7'(d1), 7'(d0)};
    ch_gain = {4'(g1), 4'(g0)};
    ch_pan  = {2'(p1), 2'(p0)};
  endtask

  // Strobe in cycle t; pcm_stb must appear only in cycle t+3.
  task automatic mix(input string tag,
                     input int l0, input int r0,
                     input int l1, input int r1);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk({tag, "_stb_t1"}, 32'(pstb0), 0);
    tick();
    chk({tag, "_stb_t2"}, 32'(pstb0), 0);
    tick();
    chk({tag, "_stb_t3"}, 32'(pstb0), 1);
    chk({tag, "_stb1_t3"}, 32'(pstb1), 1);
    chk({tag, "_l0"}, 32'(pcm_l0), 32'(l0));
    chk({tag, "_r0"}, 32'(pcm_r0), 32'(r0));
    chk({tag, "_l1"}, 32'(pcm_l1), 32'(l1));
    chk({tag, "_r1"}, 32'(pcm_r1), 32'(r1));
    tick();
    chk({tag, "_stb_t4"}, 32'(pstb0), 0);
    chk({tag, "_hold_l0"}, 32'(pcm_l0), 32'(l0));
  endtask

  initial begin
    int cnt;
    int ones_l0;
    int ones_r0;
    int ones_l1;
    int same;
    logic prev;

    reset      = 1'b1;
    sample_stb = 1'b0;
    mono       = 1'b0;
    mute       = 1'b0;
    set_ch(0, 0, 0, 0, 0, 0);

    // Reset state and quiet period.
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_pcm_l", 32'(pcm_l0), 0);
    chk("rst_pcm_r", 32'(pcm_r0), 0);
    chk("rst_stb", 32'(pstb0), 0);
    chk("rst_ovr", 32'(ovr0), 0);
    chk("rst_dac", {30'd0, dl0, dr0}, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(pstb0) + int'(pstb1);
    end
    chk("idle_no_stb", 32'(cnt), 0);

    // Single channel routed left: 127*15=1905.
    set_ch(127, 15, 1, 0, 0, 0);
    mix("left", 952, 0, 1905, 0);

    // Mono fold-down: 800+200=1000.
    mono = 1'b1;
    set_ch(100, 8, 0, 50, 4, 0);
    mix("mono", 500, 500, 1000, 1000);
    mute = 1'b1;
    mix("mute", 0, 0, 0, 0);
    mute = 1'b0;
    mono = 1'b0;

    // Saturation on the SHIFT=0 instance: 3810 -> 2047.
    set_ch(127, 15, 3, 127, 15, 3);
    mix("sat", 1905, 1905, 2047, 2047);

    // Overrun: second strobe with new data is ignored.
    set_ch(127, 15, 1, 0, 0, 0);
    sample_stb = 1'b1;
    tick();
    chk("ovr_t1", 32'(ovr0), 0);
    ch_data = {7'd0, 7'd10};
    tick();
    sample_stb = 1'b0;
    chk("ovr_t2", 32'(ovr0), 1);
    chk("ovr_t2_stb", 32'(pstb0), 0);
    tick();
    chk("ovr_t3_stb", 32'(pstb0), 1);
    chk("ovr_t3_ovr", 32'(ovr0), 0);
    chk("ovr_snap_l", 32'(pcm_l0), 952);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(pstb0);
    end
    chk("ovr_single_stb", 32'(cnt), 0);

    // Reset during ACCUM aborts the mix.
    set_ch(100, 8, 1, 0, 0, 0);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(pstb0) + int'(pstb1);
    end
    chk("abort_no_stb", 32'(cnt), 0);
    chk("abort_pcm_l0", 32'(pcm_l0), 0);
    chk("abort_pcm_l1", 32'(pcm_l1), 0);

    // Sigma-delta density: 1905+143=2048 -> 1024 / 2047.
    set_ch(127, 15, 1, 11, 13, 1);
    mix("sd", 1024, 0, 2047, 0);
    tick(2);
    ones_l0 = 0;
    ones_r0 = 0;
    ones_l1 = 0;
    same    = 0;
    prev    = ~dl0;
    for (int i = 0; i < 2048; i++) begin
      ones_l0 += int'(dl0);
      ones_r0 += int'(dr0);
      ones_l1 += int'(dl1);
      if (dl0 === prev) same++;
      prev = dl0;
      tick();
    end
    chk("sd_ones_1024", 32'(ones_l0), 1024);
    chk("sd_alternate", 32'(same), 0);
    chk("sd_zero_r", 32'(ones_r0), 0);
    chk("sd_ones_2047", 32'(ones_l1), 2047);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
